pcileech_ft601_tx_sched: RTL and testbench
==========================================

# pcileech_ft601_tx_sched

Output-side sequencer between the 256-bit FIFO controller TX stream and the 32-bit FT601 output FIFO.
- Accepts 256-bit words over a valid/ready handshake and serializes each word into eight 32-bit writes.
- Inserts a preamble of magic DWORDs at the start of every FT601 burst, as the deterministic replacement for the FTDI zero-length-termination workaround.
- Throttles on the output FIFO's almost_full flag and provides burst/word statistics.

## Interface
Parameters:
- MAGIC_COUNT, 5: number of magic DWORDs per preamble (1..15).
- MAGIC_WORD, 32'h66665555: preamble DWORD value.

Ports:
- clk  in  1  system clock (100 MHz); single clock domain.
- rst  in  1  synchronous, active-high reset.
- din  in  256  TX word; DWORD i = din[32*i+31:32*i].
- din_valid  in  1  din holds a word; must stay high with din stable until accepted.
- din_ready  out  1  combinational; word accepted in any cycle where din_valid & din_ready.
- ft601_txe_n  in  1  raw FT601 TXE_N pad; registered internally once (txe_q).
- dout  out  32  registered DWORD to output FIFO.
- dout_wr_en  out  1  registered write strobe to output FIFO.
- dout_almost_full  in  1  output FIFO almost_full; threshold must leave at least 2 free entries.
- dout_prog_empty  in  1  output FIFO prog_empty.
- stat_preambles  out  16  count of preambles issued; wraps.
- stat_words  out  32  count of 256-bit words accepted; wraps.

## Operation
- need_pre = dout_prog_empty & txe_q. It is evaluated only at word boundaries: in IDLE, and on the DWORD-7 write in DATA.
- go = ~dout_almost_full. Every write decision requires go; when go=0 nothing is written and all state holds.

States:
- IDLE
  - din_valid & go & ~need_pre: din_ready=1; latch din into the shift register; write DWORD0; idx=1; go to DATA.
  - din_valid & go & need_pre: write MAGIC_WORD; cnt=1; stat_preambles++; go to PREAMBLE.
  - otherwise: stay in IDLE with din_ready=0.
- PREAMBLE
  - Each go cycle writes MAGIC_WORD and increments cnt.
  - The cycle that writes magic #MAGIC_COUNT also asserts din_ready; din is latched with idx=0 and the state goes to DATA. din_valid is guaranteed high by the handshake rule.
  - If MAGIC_COUNT=1, IDLE accepts din in the same cycle as the single magic write and goes directly to DATA with idx=0.
- DATA
  - Each go cycle writes DWORD[idx], LSB DWORD first, then idx++.
  - On the idx=7 write:
    - din_valid & ~need_pre: din_ready=1; the new word is latched; idx=0; stay in DATA (back-to-back, no bubble).
    - din_valid & need_pre: go to IDLE without accepting. The preamble starts on the next cycle.
    - ~din_valid: go to IDLE.
- Rules at every word boundary:
  - Every accepted word is written as exactly 8 DWORDs, never interleaved with magic.
  - A preamble is only ever issued at a word boundary.
- Each accepted word increments stat_words.
- ft601_txe_n changes inside a word or preamble are ignored until the next boundary evaluation.

## Timing
- Values after rst: state=IDLE, dout=0, dout_wr_en=0, idx=0, cnt=0, txe_q=1, stat_preambles=0, stat_words=0. din_ready=0 while rst is high.
- rst mid-word or mid-preamble discards partial data. The output FIFO shares rst.
- Latency without preamble: accept in cycle N → dout_wr_en high N+1..N+8 carrying DWORD0..7.
- Latency with preamble (IDLE decision in N, no stalls): magic on N+1..N+MAGIC_COUNT; word accepted in N+MAGIC_COUNT−1; DWORD0 on N+MAGIC_COUNT+1.
- Sustained throughput: 1 DWORD per cycle.
- A go=0 cycle produces dout_wr_en=0 in the following cycle. The registered-strobe slack is covered by the 2-entry almost_full margin.
- din_ready depends combinationally on din_valid, state, idx, need_pre and dout_almost_full. There is no combinational path from din_ready to din_valid.

## Structure
- Shared package/header pcileech_ft601_pkg holds:
  - FTDI_MAGIC_DWORD = 32'h66665555 (MAGIC_WORD default).
  - State encodings ST_IDLE, ST_PRE, ST_DATA (2 bits).
  - Widths for idx (3 bits) and cnt (4 bits).
- Single module. The 8:1 DWORD mux, driven by idx from a 256-bit holding register, is inline; no sub-module.
- Instantiated between pcileech_fifo's TX port and the 32-bit output FIFO, replacing the 256→32 buffer plus workaround glue.

## Test plan
- txe_q=0, prog_empty=0, one word 256'h...0807_0605_0403_0201 packed per DWORD → 8 writes on cycles N+1..N+8, LSB DWORD first; stat_words=1; stat_preambles=0.
- txe_n=1, prog_empty=1, one word → 5 × 0x66665555 then 8 data DWORDs contiguous (13 writes, no gaps); stat_preambles=1.
- Three words back-to-back with need_pre=0 → 24 consecutive writes; din_ready high only on the cycles carrying DWORD7 of the previous word.
- dout_almost_full forced high for 4 cycles at idx=3 → write gap of exactly 4 cycles; remaining DWORDs resume in order; none lost or duplicated.
- need_pre rises during word 1 with word 2 pending → word 1 completes, then 5 magic, then word 2. Raising need_pre mid-preamble does not restart the preamble.
- rst asserted at idx=5 → next cycle dout_wr_en=0, state IDLE, counters 0; a fresh word then serializes from DWORD0.

Source files
------------

// File: rtl/pcileech_ft601_pkg.sv
// rtl/pcileech_ft601_pkg.sv - shared constants and types for the FT601 TX path
package pcileech_ft601_pkg;

    localparam logic [31:0] FTDI_MAGIC_DWORD = 32'h66665555;

    localparam int IDX_W = 3;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_DATA = 2'd2
    } tx_state_t;

endpackage

// File: rtl/pcileech_ft601_tx_sched.sv
// rtl/pcileech_ft601_tx_sched.sv - 256-to-32 TX serializer with per-burst magic preamble
module pcileech_ft601_tx_sched
    import pcileech_ft601_pkg::*;
#(
    parameter int          MAGIC_COUNT = 5,
    parameter logic [31:0] MAGIC_WORD  = FTDI_MAGIC_DWORD
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    input  logic         ft601_txe_n,
    output logic [31:0]  dout,
    output logic         dout_wr_en,
    input  logic         dout_almost_full,
    input  logic         dout_prog_empty,
    output logic [15:0]  stat_preambles,
    output logic [31:0]  stat_words
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAGIC_COUNT);

    tx_state_t        state, state_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             txe_q;
    logic [255:0]     shreg;
    logic [31:0]      dout_n;
    logic             wr_n;
    logic             ready;
    logic             pre_inc;
    logic             go;
    logic             need_pre;

    assign go        = ~dout_almost_full;
    assign need_pre  = dout_prog_empty & txe_q;
    assign din_ready = ready & ~rst;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        dout_n  = dout;
        wr_n    = 1'b0;
        ready   = 1'b0;
        pre_inc = 1'b0;
        case (state)
            ST_IDLE: begin
                if (din_valid && go) begin
                    wr_n = 1'b1;
                    if (!need_pre) begin
                        ready   = 1'b1;
                        dout_n  = din[31:0];
                        idx_n   = 3'd1;
                        state_n = ST_DATA;
                    end else begin
                        dout_n  = MAGIC_WORD;
                        cnt_n   = 4'd1;
                        pre_inc = 1'b1;
                        // A one-DWORD preamble hands straight over to the word.
                        if (MAGIC_COUNT == 1) begin
                            ready   = 1'b1;
                            idx_n   = 3'd0;
                            state_n = ST_DATA;
                        end else begin
                            state_n = ST_PRE;
                        end
                    end
                end
            end
            ST_PRE: begin
                if (go) begin
                    wr_n   = 1'b1;
                    dout_n = MAGIC_WORD;
                    cnt_n  = cnt + 1'b1;
                    if ((cnt + 1'b1) == CNT_LAST) begin
                        ready   = 1'b1;
                        idx_n   = 3'd0;
                        state_n = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (go) begin
                    wr_n   = 1'b1;
                    dout_n = shreg[{idx, 5'd0} +: 32];
                    idx_n  = idx + 1'b1;
                    if (idx == 3'd7) begin
                        // Word boundary: continue back-to-back unless a preamble is due.
                        if (din_valid && !need_pre) begin
                            ready = 1'b1;
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            idx            <= '0;
            cnt            <= '0;
            txe_q          <= 1'b1;
            dout           <= '0;
            dout_wr_en     <= 1'b0;
            stat_preambles <= '0;
            stat_words     <= '0;
        end else begin
            state          <= state_n;
            idx            <= idx_n;
            cnt            <= cnt_n;
            txe_q          <= ft601_txe_n;
            dout           <= dout_n;
            dout_wr_en     <= wr_n;
            stat_preambles <= stat_preambles + {15'd0, pre_inc};
            stat_words     <= stat_words + {31'd0, din_valid & din_ready};
        end
    end

    always_ff @(posedge clk) begin
        if (din_ready) begin
            shreg <= din;
        end
    end

endmodule

// File: tb/tb_pcileech_ft601_tx_sched.sv
// tb/tb_pcileech_ft601_tx_sched.sv - randomized self-checking bench for pcileech_ft601_tx_sched
module tb_pcileech_ft601_tx_sched;

    localparam int          MC    = 5;
    localparam logic [31:0] MAGIC = 32'h66665555;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [255:0] din = '0;
    logic         din_valid = 1'b0;
    logic         din_ready;
    logic         ft601_txe_n = 1'b1;
    logic [31:0]  dout;
    logic         dout_wr_en;
    logic         dout_almost_full = 1'b0;
    logic         dout_prog_empty = 1'b0;
    logic [15:0]  stat_preambles;
    logic [31:0]  stat_words;

    always #5 clk = ~clk;

    pcileech_ft601_tx_sched #(
        .MAGIC_COUNT (MC),
        .MAGIC_WORD  (MAGIC)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .din              (din),
        .din_valid        (din_valid),
        .din_ready        (din_ready),
        .ft601_txe_n      (ft601_txe_n),
        .dout             (dout),
        .dout_wr_en       (dout_wr_en),
        .dout_almost_full (dout_almost_full),
        .dout_prog_empty  (dout_prog_empty),
        .stat_preambles   (stat_preambles),
        .stat_words       (stat_words)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: accepted words awaiting output, with need_pre at their acceptance.
    logic [255:0] wq[$];
    bit           fq[$];
    int           wpos = 0;
    int           mag_run = 0;
    int           pre_m = 0;
    int           words_m = 0;
    logic         txeq_m = 1'b1;
    logic         af_d = 1'b0;
    logic         vld_d = 1'b0;
    logic         np_d = 1'b0;
    logic         rst_d = 1'b1;
    bit           pend = 1'b0;
    int           rst_at_pos = -1;

    function automatic logic [255:0] rand_word();
        logic [255:0] r;
        logic [31:0]  w;
        for (int i = 0; i < 8; i++) begin
            w = $urandom;
            if (w == MAGIC) w = w ^ 32'h1;
            r[32*i +: 32] = w;
        end
        return r;
    endfunction

    task automatic observe_write();
        if (dout == MAGIC) begin
            check("pre_at_boundary", 64'(wpos), 64'd0);
            if (mag_run == 0) begin
                check("pre_decision", {63'd0, np_d}, 64'd1);
                pre_m++;
            end
            mag_run++;
            check("pre_len_max", {63'd0, mag_run > MC}, 64'd0);
        end else if (wq.size() == 0) begin
            check("data_without_word", 64'(wq.size()), 64'd1);
        end else begin
            if (wpos == 0) begin
                if (mag_run > 0) check("pre_len", 64'(mag_run), 64'(MC));
                else             check("pre_skipped", {63'd0, fq[0]}, 64'd0);
                mag_run = 0;
            end
            check("data", {32'd0, dout}, {32'd0, wq[0][32*wpos +: 32]});
            wpos++;
            if (wpos == 8) begin
                wpos = 0;
                void'(wq.pop_front());
                void'(fq.pop_front());
            end
        end
    endtask

    task automatic step(input int p_af, input int p_pe, input int p_txn, input int p_vld, input int p_rst);
        logic np;
        logic exp_wr;
        @(negedge clk);
        if (rst_d) begin
            check("rst_wr_en", {63'd0, dout_wr_en}, 64'd0);
            check("rst_dout", {32'd0, dout}, 64'd0);
            check("rst_stat_pre", {48'd0, stat_preambles}, 64'd0);
            check("rst_stat_words", {32'd0, stat_words}, 64'd0);
        end else begin
            exp_wr = !af_d && (mag_run > 0 || wq.size() > 0 || vld_d);
            check("wr_en", {63'd0, dout_wr_en}, {63'd0, exp_wr});
            if (dout_wr_en) observe_write();
            check("stat_words", {32'd0, stat_words}, 64'(words_m) & 64'hFFFF_FFFF);
            check("stat_preambles", {48'd0, stat_preambles}, 64'(pre_m) & 64'hFFFF);
        end

        rst = ($urandom_range(99) < p_rst);
        if (rst_at_pos >= 0 && wq.size() > 0 && wpos == rst_at_pos) begin
            rst = 1'b1;
            rst_at_pos = -1;
        end
        if (!pend && $urandom_range(99) < p_vld) begin
            din  = rand_word();
            pend = 1'b1;
        end
        din_valid        = pend;
        dout_almost_full = ($urandom_range(99) < p_af);
        dout_prog_empty  = ($urandom_range(99) < p_pe);
        ft601_txe_n      = ($urandom_range(99) < p_txn);
        #1;
        np = dout_prog_empty & txeq_m;
        if (rst) begin
            check("rst_din_ready", {63'd0, din_ready}, 64'd0);
        end else if (din_valid && din_ready) begin
            wq.push_back(din);
            fq.push_back(np);
            words_m++;
            pend = 1'b0;
        end
        af_d   = dout_almost_full;
        vld_d  = din_valid;
        np_d   = np;
        rst_d  = rst;
        txeq_m = rst ? 1'b1 : ft601_txe_n;
        if (rst) begin
            wq.delete();
            fq.delete();
            wpos    = 0;
            mag_run = 0;
            pre_m   = 0;
            words_m = 0;
        end
    endtask

    initial begin
        repeat (3) step(0, 0, 0, 0, 100);
        repeat (150) step(0, 0, 0, 30, 0);
        repeat (150) step(0, 100, 100, 20, 0);
        repeat (200) step(0, 0, 0, 100, 0);
        repeat (400) step(30, 50, 50, 100, 0);
        repeat (600) step(10, 50, 80, 60, 0);
        rst_at_pos = 5;
        repeat (100) step(0, 30, 50, 100, 0);
        rst_at_pos = 3;
        repeat (100) step(20, 0, 0, 100, 0);
        repeat (2000) step(15, 40, 60, 70, 2);
        repeat (30) step(0, 0, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
